// File: rtl/counter_updown.sv
// Up/down modulo counter with run-time step, wrap or saturate mode, terminal-event
// flag and load range check; q/tc/err pass through a clearable DELAY-stage pipeline.

package counter_updown_pkg;
   typedef struct packed {
      logic clock;
      logic reset;
   } Data_Control_T;
endpackage

module counter_updown #(
   parameter int unsigned MAX      = 16,
   parameter int unsigned WIDTH    = $clog2(MAX),
   parameter bit          SATURATE = 1'b0,
   parameter int unsigned DELAY    = 0
) (
   input  counter_updown_pkg::Data_Control_T ctrl,
   input  logic [WIDTH-1:0]                  d,
   input  logic                              load,
   input  logic                              enable,
   input  logic                              down,
   input  logic [WIDTH-1:0]                  step,
   output logic [WIDTH-1:0]                  q,
   output logic                              tc,
   output logic                              err
);

   localparam logic [WIDTH:0]   max_w  = (WIDTH+1)'(MAX);
   localparam logic [WIDTH-1:0] top_w  = WIDTH'(MAX - 1);
   localparam bit               native = (MAX == (32'd1 << WIDTH));

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] c, c_n;
   logic             tc_r, tc_n;
   logic             err_r, err_n;
   logic [WIDTH:0]   s_up;
   logic             ovf, borrow;
   logic [WIDTH-1:0] up_wrap, dn_wrap;

   assign clk   = ctrl.clock;
   assign rst_n = ctrl.reset;

   // With MAX == 2**WIDTH the wrap result is plain modular arithmetic and the
   // overflow test is just the carry bit, so no magnitude comparator is built.
   always_comb begin
      s_up   = {1'b0, c} + {1'b0, step};
      borrow = (c < step);
      if (native) begin
         ovf     = s_up[WIDTH];
         up_wrap = c + step;
         dn_wrap = c - step;
      end else begin
         ovf     = (s_up >= max_w);
         up_wrap = WIDTH'(s_up - max_w);
         dn_wrap = WIDTH'({1'b0, c} + max_w - {1'b0, step});
      end
   end

   always_comb begin
      c_n   = c;
      tc_n  = 1'b0;
      err_n = err_r;
      if (load) begin
         if ({1'b0, d} >= max_w) begin
            c_n   = top_w;
            err_n = 1'b1;
         end else begin
            c_n   = d;
            err_n = 1'b0;
         end
      end else if (enable) begin
         if (!down) begin
            if (ovf) begin
               tc_n = 1'b1;
               c_n  = SATURATE ? top_w : up_wrap;
            end else begin
               c_n  = s_up[WIDTH-1:0];
            end
         end else begin
            if (borrow) begin
               tc_n = 1'b1;
               c_n  = SATURATE ? '0 : dn_wrap;
            end else begin
               c_n  = c - step;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c     <= '0;
         tc_r  <= 1'b0;
         err_r <= 1'b0;
      end else begin
         c     <= c_n;
         tc_r  <= tc_n;
         err_r <= err_n;
      end
   end

   generate
      if (DELAY == 0) begin : g_nodelay
         assign q   = c;
         assign tc  = tc_r;
         assign err = err_r;
      end else begin : g_delay
         logic [WIDTH+1:0] pipe [DELAY];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int unsigned i = 0; i < DELAY; i++) pipe[i] <= '0;
            end else begin
               pipe[0] <= {c, tc_r, err_r};
               for (int unsigned i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
            end
         end

         assign {q, tc, err} = pipe[DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_counter_updown.sv
// Bench for counter_updown: four parameterisations on shared stimulus, expected
// outputs queued with their due cycle and compared when that cycle arrives.

module tb_counter_updown;

   typedef struct {
      int         dut;
      int         due;
      logic [3:0] q;
      logic       tc;
      logic       err;
      string      name;
   } exp_t;

   typedef struct {
      bit ld, en, dn;
      int st, dv;
      int wq; bit wtc, werr;
      int sq; bit stc, serr;
   } row_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] d, step;
   logic       load, enable, down;
   counter_updown_pkg::Data_Control_T ctrl;

   logic [3:0] q_w, q_s, q_n, q_d;
   logic       tc_w, tc_s, tc_n, tc_d;
   logic       err_w, err_s, err_n, err_d;

   exp_t sb[$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   assign ctrl = '{clock: clk, reset: rst_n};

   always #5 clk = ~clk;

   // dut 0: MAX=10 wrap, dut 1: MAX=10 saturate, dut 2: MAX=16 wrap, dut 3: MAX=16 wrap DELAY=2
   counter_updown #(.MAX(10), .SATURATE(1'b0), .DELAY(0)) u_w (
      .ctrl(ctrl), .d(d), .load(load), .enable(enable), .down(down), .step(step),
      .q(q_w), .tc(tc_w), .err(err_w));
   counter_updown #(.MAX(10), .SATURATE(1'b1), .DELAY(0)) u_s (
      .ctrl(ctrl), .d(d), .load(load), .enable(enable), .down(down), .step(step),
      .q(q_s), .tc(tc_s), .err(err_s));
   counter_updown #(.MAX(16), .SATURATE(1'b0), .DELAY(0)) u_n (
      .ctrl(ctrl), .d(d), .load(load), .enable(enable), .down(down), .step(step),
      .q(q_n), .tc(tc_n), .err(err_n));
   counter_updown #(.MAX(16), .SATURATE(1'b0), .DELAY(2)) u_d (
      .ctrl(ctrl), .d(d), .load(load), .enable(enable), .down(down), .step(step),
      .q(q_d), .tc(tc_d), .err(err_d));

   function automatic int lat(int dut);
      return (dut == 3) ? 3 : 1;
   endfunction

   // immediate=1 is for reset, which clears the whole output pipeline on one edge
   task automatic push(int dut, int qv, bit tcv, bit errv, string nm, bit immediate = 1'b0);
      exp_t e;
      e.dut  = dut;
      e.due  = cyc + (immediate ? 1 : lat(dut));
      e.q    = 4'(qv);
      e.tc   = tcv;
      e.err  = errv;
      e.name = nm;
      sb.push_back(e);
   endtask

   function automatic bit pop_due(output exp_t e);
      foreach (sb[i]) begin
         if (sb[i].due == cyc) begin
            e = sb[i];
            sb.delete(i);
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [5:0] obs(int dut);
      case (dut)
         0:       return {q_w, tc_w, err_w};
         1:       return {q_s, tc_s, err_s};
         2:       return {q_n, tc_n, err_n};
         default: return {q_d, tc_d, err_d};
      endcase
   endfunction

   task automatic drive(bit ld, bit en, bit dn, int st, int dv);
      load   = ld;
      enable = en;
      down   = dn;
      step   = 4'(st);
      d      = 4'(dv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      exp_t e;
      logic [5:0] got;
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) rst_n = 1'b1;
         for (int k = 0; k < 3; k++) push(k, 0, 0, 0, "reset");
         if (i == 2) push(3, 0, 0, 0, "reset_delayed");
         tick();
         while (pop_due(e)) begin
            tests++;
            got = obs(e.dut);
            if (got !== {e.q, e.tc, e.err}) begin
               fails++;
               $display("FAIL %s dut=%0d cyc=%0d got q=%0d tc=%b err=%b want q=%0d tc=%b err=%b",
                        e.name, e.dut, cyc, got[5:2], got[1], got[0], e.q, e.tc, e.err);
            end
         end
      end
   endtask

   task automatic test_count_up();
      exp_t e;
      logic [5:0] got;
      drive(0, 1, 0, 1, 0);
      for (int i = 0; i < 12; i++) begin
         push(0, (i + 1) % 10, i == 9, 0, "count_wrap");
         push(1, (i + 1 > 9) ? 9 : i + 1, i >= 9, 0, "count_sat");
         push(2, (i + 1) % 16, 0, 0, "count_native");
         tick();
         while (pop_due(e)) begin
            tests++;
            got = obs(e.dut);
            if (got !== {e.q, e.tc, e.err}) begin
               fails++;
               $display("FAIL %s dut=%0d cyc=%0d got q=%0d tc=%b err=%b want q=%0d tc=%b err=%b",
                        e.name, e.dut, cyc, got[5:2], got[1], got[0], e.q, e.tc, e.err);
            end
         end
      end
   endtask

   task automatic test_wrap_down();
      exp_t e;
      logic [5:0] got;
      row_t tbl [3] = '{
         '{1, 0, 0, 0, 2,  2, 0, 0,  2, 0, 0},
         '{0, 1, 1, 3, 0,  9, 1, 0,  0, 1, 0},
         '{0, 1, 1, 3, 0,  6, 0, 0,  0, 1, 0}};
      foreach (tbl[r]) begin
         drive(tbl[r].ld, tbl[r].en, tbl[r].dn, tbl[r].st, tbl[r].dv);
         push(0, tbl[r].wq, tbl[r].wtc, tbl[r].werr, "wrap_down_w");
         push(1, tbl[r].sq, tbl[r].stc, tbl[r].serr, "wrap_down_s");
         tick();
         while (pop_due(e)) begin
            tests++;
            got = obs(e.dut);
            if (got !== {e.q, e.tc, e.err}) begin
               fails++;
               $display("FAIL %s dut=%0d cyc=%0d got q=%0d tc=%b err=%b want q=%0d tc=%b err=%b",
                        e.name, e.dut, cyc, got[5:2], got[1], got[0], e.q, e.tc, e.err);
            end
         end
      end
   endtask

   task automatic test_saturate();
      exp_t e;
      logic [5:0] got;
      row_t tbl [6] = '{
         '{1, 0, 0, 0, 8,  8, 0, 0,  8, 0, 0},
         '{0, 1, 0, 3, 0,  1, 1, 0,  9, 1, 0},
         '{0, 1, 0, 3, 0,  4, 0, 0,  9, 1, 0},
         '{0, 1, 1, 4, 0,  0, 0, 0,  5, 0, 0},
         '{0, 1, 1, 4, 0,  6, 1, 0,  1, 0, 0},
         '{0, 1, 1, 4, 0,  2, 0, 0,  0, 1, 0}};
      foreach (tbl[r]) begin
         drive(tbl[r].ld, tbl[r].en, tbl[r].dn, tbl[r].st, tbl[r].dv);
         push(0, tbl[r].wq, tbl[r].wtc, tbl[r].werr, "saturate_w");
         push(1, tbl[r].sq, tbl[r].stc, tbl[r].serr, "saturate_s");
         tick();
         while (pop_due(e)) begin
            tests++;
            got = obs(e.dut);
            if (got !== {e.q, e.tc, e.err}) begin
               fails++;
               $display("FAIL %s dut=%0d cyc=%0d got q=%0d tc=%b err=%b want q=%0d tc=%b err=%b",
                        e.name, e.dut, cyc, got[5:2], got[1], got[0], e.q, e.tc, e.err);
            end
         end
      end
   endtask

   task automatic test_load_err();
      exp_t e;
      logic [5:0] got;
      row_t tbl [6] = '{
         '{1, 1, 0, 1, 12,  9, 0, 1,  9, 0, 1},
         '{0, 1, 0, 1, 0,   0, 1, 1,  9, 1, 1},
         '{0, 0, 0, 0, 0,   0, 0, 1,  9, 0, 1},
         '{1, 0, 0, 0, 10,  9, 0, 1,  9, 0, 1},
         '{1, 1, 1, 3, 4,   4, 0, 0,  4, 0, 0},
         '{1, 0, 0, 0, 9,   9, 0, 0,  9, 0, 0}};
      foreach (tbl[r]) begin
         drive(tbl[r].ld, tbl[r].en, tbl[r].dn, tbl[r].st, tbl[r].dv);
         push(0, tbl[r].wq, tbl[r].wtc, tbl[r].werr, "load_err_w");
         push(1, tbl[r].sq, tbl[r].stc, tbl[r].serr, "load_err_s");
         if (r == 0) push(2, 12, 0, 0, "load_in_range_native");
         tick();
         while (pop_due(e)) begin
            tests++;
            got = obs(e.dut);
            if (got !== {e.q, e.tc, e.err}) begin
               fails++;
               $display("FAIL %s dut=%0d cyc=%0d got q=%0d tc=%b err=%b want q=%0d tc=%b err=%b",
                        e.name, e.dut, cyc, got[5:2], got[1], got[0], e.q, e.tc, e.err);
            end
         end
      end
   endtask

   task automatic test_delay_reset();
      exp_t e;
      logic [5:0] got;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: begin
               drive(1, 0, 0, 0, 15);
               push(2, 15, 0, 0, "delay0_load");
               push(3, 15, 0, 0, "delay2_load");
            end
            1: begin
               drive(0, 1, 0, 1, 0);
               push(2, 0, 1, 0, "delay0_wrap");
               push(3, 0, 1, 0, "delay2_wrap");
            end
            2: push(2, 1, 0, 0, "delay0_count");
            3: push(2, 2, 0, 0, "delay0_count");
            4: begin
               rst_n = 1'b0;
               push(2, 0, 0, 0, "delay0_midreset", 1'b1);
               push(3, 0, 0, 0, "delay2_midreset", 1'b1);
            end
            default: begin
               rst_n = 1'b1;
               drive(0, 0, 0, 0, 0);
               push(2, 0, 0, 0, "delay0_after_reset", 1'b1);
               push(3, 0, 0, 0, "delay2_no_stale", 1'b1);
            end
         endcase
         tick();
         while (pop_due(e)) begin
            tests++;
            got = obs(e.dut);
            if (got !== {e.q, e.tc, e.err}) begin
               fails++;
               $display("FAIL %s dut=%0d cyc=%0d got q=%0d tc=%b err=%b want q=%0d tc=%b err=%b",
                        e.name, e.dut, cyc, got[5:2], got[1], got[0], e.q, e.tc, e.err);
            end
         end
      end
   endtask

   task automatic test_step_zero_hold();
      exp_t e;
      logic [5:0] got;
      row_t tbl [8] = '{
         '{1, 0, 0, 0, 5,  5, 0, 0,  5, 0, 0},
         '{0, 1, 0, 0, 0,  5, 0, 0,  5, 0, 0},
         '{0, 1, 1, 0, 0,  5, 0, 0,  5, 0, 0},
         '{0, 1, 0, 1, 0,  6, 0, 0,  6, 0, 0},
         '{0, 0, 0, 1, 0,  6, 0, 0,  6, 0, 0},
         '{0, 0, 1, 3, 0,  6, 0, 0,  6, 0, 0},
         '{0, 0, 0, 7, 0,  6, 0, 0,  6, 0, 0},
         '{0, 1, 0, 1, 0,  7, 0, 0,  7, 0, 0}};
      foreach (tbl[r]) begin
         drive(tbl[r].ld, tbl[r].en, tbl[r].dn, tbl[r].st, tbl[r].dv);
         push(0, tbl[r].wq, tbl[r].wtc, tbl[r].werr, "step0_hold_w");
         push(1, tbl[r].sq, tbl[r].stc, tbl[r].serr, "step0_hold_s");
         tick();
         while (pop_due(e)) begin
            tests++;
            got = obs(e.dut);
            if (got !== {e.q, e.tc, e.err}) begin
               fails++;
               $display("FAIL %s dut=%0d cyc=%0d got q=%0d tc=%b err=%b want q=%0d tc=%b err=%b",
                        e.name, e.dut, cyc, got[5:2], got[1], got[0], e.q, e.tc, e.err);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap_down();
      test_saturate();
      test_load_err();
      test_delay_reset();
      test_step_zero_hold();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
